// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: instruction opcodes, loader FSM
// states and word/field widths. Imported by instr_encoder and prog_loader.
package prog_loader_pkg;

    localparam int unsigned AddrW = 8;
    localparam int unsigned CountW = 8;
    localparam int unsigned WordW = 32;

    // Instruction opcodes (7-bit). Any value not listed here is illegal.
    localparam logic [6:0] OpNop = 7'h00;
    localparam logic [6:0] OpAdd = 7'h02;
    localparam logic [6:0] OpSub = 7'h05;
    localparam logic [6:0] OpSlt = 7'h65;
    localparam logic [6:0] OpAnd = 7'h08;
    localparam logic [6:0] OpOr  = 7'h09;
    localparam logic [6:0] OpXor = 7'h0A;
    localparam logic [6:0] OpSt  = 7'h01;
    localparam logic [6:0] OpLod = 7'h21;
    localparam logic [6:0] OpAdi = 7'h22;
    localparam logic [6:0] OpSbi = 7'h25;
    localparam logic [6:0] OpNot = 7'h2E;
    localparam logic [6:0] OpAni = 7'h28;
    localparam logic [6:0] OpOri = 7'h29;
    localparam logic [6:0] OpXri = 7'h2A;
    localparam logic [6:0] OpAiu = 7'h62;
    localparam logic [6:0] OpSiu = 7'h45;
    localparam logic [6:0] OpMov = 7'h40;
    localparam logic [6:0] OpLsl = 7'h30;
    localparam logic [6:0] OpLsr = 7'h31;
    localparam logic [6:0] OpJmr = 7'h61;
    localparam logic [6:0] OpBz  = 7'h20;
    localparam logic [6:0] OpBnz = 7'h60;
    localparam logic [6:0] OpJmp = 7'h44;
    localparam logic [6:0] OpJml = 7'h07;

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StWrite,
        StFin
    } state_e;

endpackage

// File: rtl/instr_encoder.sv
// Combinational instruction packer and opcode legality checker.
// Ports:
//   opcode_i, dr_i, sa_i, sb_i, imm_i, use_imm_i : instruction fields
//   word_o  : packed 32-bit instruction word
//   legal_o : 1 when opcode_i is a known opcode
module instr_encoder
    import prog_loader_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  dr_i,
    input  logic [4:0]  sa_i,
    input  logic [4:0]  sb_i,
    input  logic [14:0] imm_i,
    input  logic        use_imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        legal_o = 1'b0;
        unique case (opcode_i)
            OpNop, OpAdd, OpSub, OpSlt, OpAnd, OpOr, OpXor, OpSt, OpLod,
            OpAdi, OpSbi, OpNot, OpAni, OpOri, OpXri, OpAiu, OpSiu, OpMov,
            OpLsl, OpLsr, OpJmr, OpBz, OpBnz, OpJmp, OpJml: legal_o = 1'b1;
            default: legal_o = 1'b0;
        endcase
    end

    always_comb begin
        word_o = {opcode_i, dr_i, sa_i, (use_imm_i ? imm_i : {sb_i, 10'b0})};
        // NOP carries no operands; clear them so stale fields never leak into memory.
        if (opcode_i == OpNop) begin
            word_o[24:0] = '0;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts instruction fields over a valid/ready handshake,
// packs them and writes them to consecutive instruction-memory addresses.
// Ports:
//   CLK, RESET_N          : clock, async active-low reset
//   START, BASE_ADDR, COUNT : session start, first address, word count
//   IN_VALID / IN_READY   : field handshake; IN_OPCODE..IN_USE_IMM fields
//   MEM_WE, MEM_ADDR, MEM_WDATA : instruction-memory write port
//   BUSY, DONE            : session active, one-cycle end-of-session pulse
//   ERR, ERR_ADDR         : sticky illegal-opcode flag and its address
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [7:0]  BASE_ADDR,
    input  logic [7:0]  COUNT,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [6:0]  IN_OPCODE,
    input  logic [4:0]  IN_DR,
    input  logic [4:0]  IN_SA,
    input  logic [4:0]  IN_SB,
    input  logic [14:0] IN_IMM,
    input  logic        IN_USE_IMM,
    output logic        MEM_WE,
    output logic [7:0]  MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [7:0]  ERR_ADDR
);

    state_e            state_q, state_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [CountW-1:0] count_q, count_d;
    logic [AddrW-1:0]  mem_addr_q, mem_addr_d;
    logic [WordW-1:0]  mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;
    logic [AddrW-1:0]  err_addr_q, err_addr_d;

    logic [WordW-1:0]  enc_word;
    logic              enc_legal;

    instr_encoder u_encoder (
        .opcode_i  (IN_OPCODE),
        .dr_i      (IN_DR),
        .sa_i      (IN_SA),
        .sb_i      (IN_SB),
        .imm_i     (IN_IMM),
        .use_imm_i (IN_USE_IMM),
        .word_o    (enc_word),
        .legal_o   (enc_legal)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    addr_d  = BASE_ADDR;
                    count_d = COUNT;
                    err_d   = 1'b0;
                    state_d = (COUNT == '0) ? StFin : StAccept;
                end
            end
            StAccept: begin
                if (IN_VALID) begin
                    if (enc_legal) begin
                        // Write port registers double as the word register, so they
                        // naturally hold their last values between writes.
                        mem_addr_d  = addr_q;
                        mem_wdata_d = enc_word;
                        state_d     = StWrite;
                    end else begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                        state_d    = StFin;
                    end
                end
            end
            StWrite: begin
                addr_d  = addr_q + 8'd1;  // wraps FF -> 00
                count_d = count_q - 8'd1;
                state_d = (count_q == 8'd1) ? StFin : StAccept;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Decoded straight from the state register so reset clears them at once.
    assign IN_READY  = (state_q == StAccept);
    assign MEM_WE    = (state_q == StWrite);
    assign BUSY      = (state_q != StIdle);
    assign DONE      = (state_q == StFin);
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign ERR       = err_q;
    assign ERR_ADDR  = err_addr_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

    localparam logic [6:0] TbNop = 7'h00;
    localparam logic [6:0] TbAdd = 7'h02;
    localparam logic [6:0] TbSub = 7'h05;
    localparam logic [6:0] TbAdi = 7'h22;
    localparam logic [6:0] TbXor = 7'h0A;
    localparam logic [6:0] TbBad = 7'h7F;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  BASE_ADDR = '0;
    logic [7:0]  COUNT = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [6:0]  IN_OPCODE = '0;
    logic [4:0]  IN_DR = '0;
    logic [4:0]  IN_SA = '0;
    logic [4:0]  IN_SB = '0;
    logic [14:0] IN_IMM = '0;
    logic        IN_USE_IMM = 1'b0;
    logic        MEM_WE;
    logic [7:0]  MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [7:0]  ERR_ADDR;

    int n_cmp = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    always #5 CLK = ~CLK;

    prog_loader dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .START      (START),
        .BASE_ADDR  (BASE_ADDR),
        .COUNT      (COUNT),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_OPCODE  (IN_OPCODE),
        .IN_DR      (IN_DR),
        .IN_SA      (IN_SA),
        .IN_SB      (IN_SB),
        .IN_IMM     (IN_IMM),
        .IN_USE_IMM (IN_USE_IMM),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR),
        .ERR_ADDR   (ERR_ADDR)
    );

    // Event counters sampled mid-cycle.
    always @(negedge CLK) begin
        if (MEM_WE === 1'b1) wr_cnt++;
        if (DONE === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_session(input logic [7:0] base, input logic [7:0] cnt);
        START = 1'b1;
        BASE_ADDR = base;
        COUNT = cnt;
        step();
        START = 1'b0;
        BASE_ADDR = 8'hAA;
        COUNT = 8'h55;
    endtask

    // Presents one set of fields and completes the handshake; returns one cycle
    // after the accepting edge.
    task automatic send_word(input logic [6:0] op, input logic [4:0] dr, input logic [4:0] sa,
                             input logic [4:0] sb, input logic [14:0] imm, input logic use_imm);
        int waited = 0;
        while (IN_READY !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (IN_READY !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: IN_READY=%b after %0d cycles, want 1", IN_READY, waited);
        end
        IN_OPCODE = op;
        IN_DR = dr;
        IN_SA = sa;
        IN_SB = sb;
        IN_IMM = imm;
        IN_USE_IMM = use_imm;
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        IN_OPCODE = 7'h7F;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        step();
        step();
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_cmp++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", IN_READY); end
        n_cmp++; if ({MEM_WE, DONE, ERR} !== 3'b000) begin n_fail++; $display("FAIL reset_we_done_err: got %b want 000", {MEM_WE, DONE, ERR}); end
        n_cmp++; if ({MEM_ADDR, ERR_ADDR} !== 16'h0) begin n_fail++; $display("FAIL reset_addrs: got %h want 0000", {MEM_ADDR, ERR_ADDR}); end
        n_cmp++; if (MEM_WDATA !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", MEM_WDATA); end
        RESET_N = 1'b1;
        step();
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_single_add();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        logic [31:0] exp_w = {TbAdd, 5'd3, 5'd1, 5'd2, 10'b0};
        start_session(8'h10, 8'd1);
        n_cmp++; if ({BUSY, IN_READY} !== 2'b11) begin n_fail++; $display("FAIL add_accept: busy/ready got %b want 11", {BUSY, IN_READY}); end
        send_word(TbAdd, 5'd3, 5'd1, 5'd2, 15'h1234, 1'b0);
        n_cmp++; if (MEM_WE !== 1'b1) begin n_fail++; $display("FAIL add_we: got %b want 1", MEM_WE); end
        n_cmp++; if (MEM_ADDR !== 8'h10) begin n_fail++; $display("FAIL add_addr: got %h want 10", MEM_ADDR); end
        n_cmp++; if (MEM_WDATA !== exp_w) begin n_fail++; $display("FAIL add_wdata: got %h want %h", MEM_WDATA, exp_w); end
        step();
        n_cmp++; if ({DONE, MEM_WE} !== 2'b10) begin n_fail++; $display("FAIL add_done: done/we got %b want 10", {DONE, MEM_WE}); end
        step();
        n_cmp++; if ({DONE, BUSY} !== 2'b00) begin n_fail++; $display("FAIL add_idle: done/busy got %b want 00", {DONE, BUSY}); end
        n_cmp++; if ({MEM_ADDR, MEM_WDATA} !== {8'h10, exp_w}) begin n_fail++; $display("FAIL add_hold: got %h want %h", {MEM_ADDR, MEM_WDATA}, {8'h10, exp_w}); end
        n_cmp++; if ((wr_cnt - w0) != 1 || (done_cnt - d0) != 1) begin n_fail++; $display("FAIL add_counts: writes %0d dones %0d want 1 1", wr_cnt - w0, done_cnt - d0); end
    endtask

    task automatic test_imm();
        logic [31:0] exp_w = {TbAdi, 5'd4, 5'd4, 15'h7FFF};
        start_session(8'h30, 8'd1);
        send_word(TbAdi, 5'd4, 5'd4, 5'd9, 15'h7FFF, 1'b1);
        n_cmp++; if (MEM_WDATA[14:0] !== 15'h7FFF) begin n_fail++; $display("FAIL adi_imm: got %h want 7fff", MEM_WDATA[14:0]); end
        n_cmp++; if (MEM_WDATA !== exp_w) begin n_fail++; $display("FAIL adi_wdata: got %h want %h", MEM_WDATA, exp_w); end
        step();
        step();
    endtask

    task automatic test_nop();
        logic [31:0] exp_w = {TbNop, 25'b0};
        start_session(8'h31, 8'd1);
        send_word(TbNop, 5'd31, 5'd31, 5'd31, 15'h7FFF, 1'b0);
        n_cmp++; if ({MEM_WE, MEM_WDATA} !== {1'b1, exp_w}) begin n_fail++; $display("FAIL nop_wdata: got %h want %h", {MEM_WE, MEM_WDATA}, {1'b1, exp_w}); end
        step();
        step();
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [3] = '{8'hFE, 8'hFF, 8'h00};
        logic [31:0] exp_w;
        int w0 = wr_cnt;
        start_session(8'hFE, 8'd3);
        for (int i = 0; i < 3; i++) begin
            send_word(TbXor, 5'(i + 1), 5'(i + 2), 5'(i + 3), 15'h0, 1'b0);
            exp_w = {TbXor, 5'(i + 1), 5'(i + 2), 5'(i + 3), 10'b0};
            n_cmp++; if ({MEM_WE, MEM_ADDR} !== {1'b1, exp_a[i]}) begin n_fail++; $display("FAIL wrap_addr%0d: we/addr got %h want %h", i, {MEM_WE, MEM_ADDR}, {1'b1, exp_a[i]}); end
            n_cmp++; if (MEM_WDATA !== exp_w) begin n_fail++; $display("FAIL wrap_data%0d: got %h want %h", i, MEM_WDATA, exp_w); end
            step();
            if (i < 2) begin
                n_cmp++; if ({IN_READY, DONE} !== 2'b10) begin n_fail++; $display("FAIL wrap_ready%0d: ready/done got %b want 10", i, {IN_READY, DONE}); end
            end else begin
                n_cmp++; if ({IN_READY, DONE} !== 2'b01) begin n_fail++; $display("FAIL wrap_done: ready/done got %b want 01", {IN_READY, DONE}); end
            end
        end
        step();
        n_cmp++; if ((wr_cnt - w0) != 3) begin n_fail++; $display("FAIL wrap_count: got %0d want 3", wr_cnt - w0); end
    endtask

    task automatic test_illegal();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        start_session(8'h20, 8'd4);
        send_word(TbSub, 5'd1, 5'd2, 5'd3, 15'h0, 1'b0);
        n_cmp++; if ({MEM_WE, MEM_ADDR} !== {1'b1, 8'h20}) begin n_fail++; $display("FAIL ill_first: we/addr got %h want 120", {MEM_WE, MEM_ADDR}); end
        step();
        send_word(TbBad, 5'd1, 5'd2, 5'd3, 15'h0, 1'b0);
        n_cmp++; if ({MEM_WE, DONE, ERR} !== 3'b011) begin n_fail++; $display("FAIL ill_abort: we/done/err got %b want 011", {MEM_WE, DONE, ERR}); end
        n_cmp++; if (ERR_ADDR !== 8'h21) begin n_fail++; $display("FAIL ill_erraddr: got %h want 21", ERR_ADDR); end
        step();
        n_cmp++; if ({BUSY, ERR} !== 2'b01) begin n_fail++; $display("FAIL ill_sticky: busy/err got %b want 01", {BUSY, ERR}); end
        n_cmp++; if ((wr_cnt - w0) != 1 || (done_cnt - d0) != 1) begin n_fail++; $display("FAIL ill_counts: writes %0d dones %0d want 1 1", wr_cnt - w0, done_cnt - d0); end
        // Zero-length session: clears ERR, pulses DONE one cycle later, writes nothing.
        start_session(8'h50, 8'd0);
        n_cmp++; if ({DONE, ERR, MEM_WE} !== 3'b100) begin n_fail++; $display("FAIL zero_done: done/err/we got %b want 100", {DONE, ERR, MEM_WE}); end
        step();
        n_cmp++; if ({BUSY, DONE, MEM_ADDR} !== {2'b00, 8'h20}) begin n_fail++; $display("FAIL zero_idle: got %h want 020", {BUSY, DONE, MEM_ADDR}); end
        n_cmp++; if ((wr_cnt - w0) != 1) begin n_fail++; $display("FAIL zero_writes: got %0d want 1", wr_cnt - w0); end
    endtask

    task automatic test_ignore_start();
        start_session(8'h40, 8'd2);
        START = 1'b1;
        BASE_ADDR = 8'h80;
        COUNT = 8'd9;
        step();
        START = 1'b0;
        n_cmp++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL ign_ready: got %b want 1", IN_READY); end
        send_word(TbAdd, 5'd0, 5'd0, 5'd0, 15'h0, 1'b0);
        n_cmp++; if ({MEM_WE, MEM_ADDR} !== {1'b1, 8'h40}) begin n_fail++; $display("FAIL ign_addr0: got %h want 140", {MEM_WE, MEM_ADDR}); end
        step();
        send_word(TbAdd, 5'd0, 5'd0, 5'd0, 15'h0, 1'b0);
        n_cmp++; if ({MEM_WE, MEM_ADDR} !== {1'b1, 8'h41}) begin n_fail++; $display("FAIL ign_addr1: got %h want 141", {MEM_WE, MEM_ADDR}); end
        step();
        n_cmp++; if (DONE !== 1'b1) begin n_fail++; $display("FAIL ign_done: got %b want 1", DONE); end
        step();
    endtask

    task automatic test_reset_mid();
        int w0;
        int d0;
        start_session(8'h60, 8'd2);
        send_word(TbAdd, 5'd5, 5'd6, 5'd7, 15'h0, 1'b0);
        n_cmp++; if (MEM_WE !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we: got %b want 1", MEM_WE); end
        w0 = wr_cnt;
        d0 = done_cnt;
        #2;
        RESET_N = 1'b0;
        #1;
        n_cmp++; if ({MEM_WE, BUSY, IN_READY, DONE} !== 4'b0000) begin n_fail++; $display("FAIL rst_async: we/busy/ready/done got %b want 0000", {MEM_WE, BUSY, IN_READY, DONE}); end
        n_cmp++; if ({MEM_ADDR, MEM_WDATA} !== 40'h0) begin n_fail++; $display("FAIL rst_async_port: got %h want 0", {MEM_ADDR, MEM_WDATA}); end
        step();
        RESET_N = 1'b1;
        step();
        step();
        n_cmp++; if ((wr_cnt - w0) != 0 || (done_cnt - d0) != 0) begin n_fail++; $display("FAIL rst_abandon: writes %0d dones %0d want 0 0", wr_cnt - w0, done_cnt - d0); end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got %b want 0", BUSY); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_imm();
        test_nop();
        test_wrap();
        test_illegal();
        test_ignore_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
